aes_pipe_sched: RTL and testbench

Round-robin scheduler that shares one fully pipelined AES-128 encryption core among `NREQ` requesters. It accepts one plaintext/key pair per cycle through per-requester valid/ready handshakes and drives the core inputs. A requester-ID tag shift register tracks each block through the core's fixed latency, so every ciphertext is returned to the requester that issued it. Per-requester outstanding-block counters cap how much of the pipeline any one requester can occupy.

---
 rtl/aes_pipe_sched.sv | 182 ++++++++++++++++++
 tb/tb_aes_pipe_sched.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pipe_sched.sv
// Round-robin scheduler sharing one pipelined AES-128 core among NREQ requesters,
// with per-requester in-flight limits. Define AES_SCHED_PRIO_EN for strict priority of requester 0.
module aes_pipe_sched #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 12,
    parameter int MAX_OUT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*128-1:0] req_data,
    input  logic [NREQ*128-1:0] req_key,
    output logic [127:0]        core_data_o,
    output logic [127:0]        core_key_o,
    input  logic [127:0]        core_result_i,
    output logic [NREQ-1:0]     resp_valid,
    output logic [127:0]        resp_data,
    output logic                busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUT);
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    function automatic logic [NREQ-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] oh;
        oh = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (id == IDW'(i));
        end
        return oh;
    endfunction

    logic [IDW-1:0]  ptr_r;
    logic [CW-1:0]   cnt_r [NREQ];
    logic            tag_vld_r [0:LATENCY];
    logic [IDW-1:0]  tag_id_r [0:LATENCY];
    logic [127:0]    core_data_r;
    logic [127:0]    core_key_r;
    logic [NREQ-1:0] resp_valid_r;
    logic [127:0]    resp_data_r;
    logic            busy_r;

    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [IDW-1:0]  cand_s;
    logic            xfer_s;
    logic [127:0]    sel_data_s;
    logic [127:0]    sel_key_s;
    logic            ret_vld_s;
    logic [NREQ-1:0] ret_oh_s;
    logic            busy_nxt_s;

    assign req_ready   = gnt_s;
    assign core_data_o = core_data_r;
    assign core_key_o  = core_key_r;
    assign resp_valid  = resp_valid_r;
    assign resp_data   = resp_data_r;
    assign busy        = busy_r;

    assign ret_vld_s = tag_vld_r[LATENCY];
    assign ret_oh_s  = ret_vld_s ? id_onehot(tag_id_r[LATENCY]) : {NREQ{1'b0}};

    // Eligibility: valid and below the in-flight limit
    always_comb begin
        elig_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = req_valid[i] && (cnt_r[i] < CNT_MAX);
        end
    end

    // Grant: first eligible requester after ptr; in priority mode requester 0 wins outright
    always_comb begin
        gnt_s     = {NREQ{1'b0}};
        gnt_idx_s = {IDW{1'b0}};
        cand_s    = {IDW{1'b0}};
        xfer_s    = 1'b0;
`ifdef AES_SCHED_PRIO_EN
        if (elig_s[0]) begin
            gnt_s[0] = 1'b1;
            xfer_s   = 1'b1;
        end else begin
            xfer_s   = 1'b0;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDW'((int'(ptr_r) + k) % NREQ);
            if (!xfer_s && elig_s[cand_s]) begin
                gnt_s[cand_s] = 1'b1;
                gnt_idx_s     = cand_s;
                xfer_s        = 1'b1;
            end else begin
                gnt_idx_s     = gnt_idx_s;
            end
        end
    end

    // Granted plaintext/key slice select (grant is one-hot or zero)
    always_comb begin
        sel_data_s = 128'd0;
        sel_key_s  = 128'd0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = sel_data_s | (req_data[128*i +: 128] & {128{gnt_s[i]}});
            sel_key_s  = sel_key_s  | (req_key[128*i +: 128]  & {128{gnt_s[i]}});
        end
    end

    // Busy after the next edge: new tag entering, or any tag not about to leave the pipe
    always_comb begin
        busy_nxt_s = xfer_s;
        for (int s = 0; s < LATENCY; s++) begin
            busy_nxt_s = busy_nxt_s | tag_vld_r[s];
        end
    end

    // Tag shift register following each block through the core
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= LATENCY; s++) begin
                tag_vld_r[s] <= 1'b0;
                tag_id_r[s]  <= {IDW{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= xfer_s;
            tag_id_r[0]  <= gnt_idx_s;
            for (int s = 1; s <= LATENCY; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_id_r[s]  <= tag_id_r[s-1];
            end
        end
    end

    // Core input registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            core_data_r <= 128'd0;
            core_key_r  <= 128'd0;
            ptr_r       <= PTR_RST;
        end else if (xfer_s) begin
            core_data_r <= sel_data_s;
            core_key_r  <= sel_key_s;
`ifdef AES_SCHED_PRIO_EN
            if (gnt_idx_s != {IDW{1'b0}}) begin
                ptr_r <= gnt_idx_s;
            end
`else
            ptr_r       <= gnt_idx_s;
`endif
        end
    end

    // Outstanding counters; a simultaneous issue and return leaves the count unchanged
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                cnt_r[i] <= {CW{1'b0}};
            end else if (gnt_s[i] && !ret_oh_s[i] && (cnt_r[i] < CNT_MAX)) begin
                cnt_r[i] <= cnt_r[i] + CW'(1);
            end else if (ret_oh_s[i] && !gnt_s[i] && (cnt_r[i] != {CW{1'b0}})) begin
                cnt_r[i] <= cnt_r[i] - CW'(1);
            end
        end
    end

    // Response registers and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= {NREQ{1'b0}};
            resp_data_r  <= 128'd0;
            busy_r       <= 1'b0;
        end else begin
            resp_valid_r <= ret_oh_s;
            busy_r       <= busy_nxt_s;
            if (ret_vld_s) begin
                resp_data_r <= core_result_i;
            end
        end
    end

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Bench for aes_pipe_sched: behavioural AES core in the loop, queue-based scheduler model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_aes_pipe_sched;
    localparam int NREQ    = 4;
    localparam int LATENCY = 12;
    localparam int MAX_OUT = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ*128-1:0] req_key;
    logic [127:0]        core_data_o;
    logic [127:0]        core_key_o;
    logic [127:0]        core_result_i;
    logic [NREQ-1:0]     resp_valid;
    logic [127:0]        resp_data;
    logic                busy;

    aes_pipe_sched #(.NREQ(NREQ), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .core_data_o(core_data_o),
        .core_key_o(core_key_o), .core_result_i(core_result_i), .resp_valid(resp_valid),
        .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    initial begin
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(a));
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) out[127-8*n -: 8] = s[n];
        return out;
    endfunction

    // Pipelined core stand-in: result appears LATENCY cycles after its inputs update
    logic [127:0] core_pipe [LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= aes128(core_data_o, core_key_o);
        for (int s = 1; s < LATENCY; s++) core_pipe[s] <= core_pipe[s-1];
    end
    assign core_result_i = core_pipe[LATENCY-1];

    // ---------------- scheduler model and per-cycle compare ----------------
    typedef struct {
        int           id;
        int           ret_edge;
        logic [127:0] ct;
    } blk_t;

    blk_t            inflight[$];
    int              m_ptr;
    int              m_cnt [NREQ];
    int              edge_n = 0;
    int              cyc_n = 0;
    bit              m_live = 1'b0;
    logic [127:0]    m_core_d, m_core_k, m_resp_d;
    logic [NREQ-1:0] m_resp_v;
    logic            m_busy;
    int              n_cmp = 0;
    int              n_bad = 0;

    int              gnt_log[$];
    int              gnt_cyc[$];
    logic [NREQ-1:0] resp_v_log[$];
    logic [127:0]    resp_d_log[$];
    int              resp_cyc[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc_n, act, exp);
        end
    endtask

    function automatic int model_grant();
        bit el [NREQ];
        for (int i = 0; i < NREQ; i++) el[i] = req_valid[i] && (m_cnt[i] < MAX_OUT);
`ifdef AES_SCHED_PRIO_EN
        if (el[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++)
            if (el[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin : cmp_p
        int              g;
        blk_t            b;
        logic [NREQ-1:0] exp_ready;
        cyc_n = cyc_n + 1;
        g = m_live ? model_grant() : -1;
        if (m_live) begin
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 128'(req_ready), 128'(exp_ready));
            check("core_data", core_data_o, m_core_d);
            check("core_key", core_key_o, m_core_k);
            check("resp_valid", 128'(resp_valid), 128'(m_resp_v));
            check("resp_data", resp_data, m_resp_d);
            check("busy", 128'(busy), 128'(m_busy));
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i] && req_valid[i]) begin
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc_n);
                end
            if (resp_valid != '0) begin
                resp_v_log.push_back(resp_valid);
                resp_d_log.push_back(resp_data);
                resp_cyc.push_back(cyc_n);
            end
        end
        edge_n = edge_n + 1;
        if (reset) begin
            m_live = 1'b1;
            m_ptr = NREQ - 1;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
            inflight.delete();
            m_core_d = '0; m_core_k = '0; m_resp_d = '0; m_resp_v = '0; m_busy = 1'b0;
        end else if (m_live) begin
            m_resp_v = '0;
            if (inflight.size() > 0 && inflight[0].ret_edge == edge_n) begin
                b = inflight.pop_front();
                m_resp_v[b.id] = 1'b1;
                m_resp_d = b.ct;
                m_cnt[b.id] = m_cnt[b.id] - 1;
            end
            if (g >= 0) begin
                m_core_d = req_data[g*128 +: 128];
                m_core_k = req_key[g*128 +: 128];
                m_cnt[g] = m_cnt[g] + 1;
`ifdef AES_SCHED_PRIO_EN
                if (g != 0) m_ptr = g;
`else
                m_ptr = g;
`endif
                b.id = g;
                b.ret_edge = edge_n + LATENCY + 1;
                b.ct = aes128(m_core_d, m_core_k);
                inflight.push_back(b);
            end
            m_busy = (inflight.size() != 0);
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); gnt_cyc.delete();
        resp_v_log.delete(); resp_d_log.delete(); resp_cyc.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [127:0] pat(input int i, input int c, input int salt);
        return {32'(salt), 32'(i), 32'(c), 32'h5a5a0000 ^ 32'(i * 7 + c)};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [127:0] d, input logic [127:0] k);
        req_valid[i] = v;
        req_data[i*128 +: 128] = d;
        req_key[i*128 +: 128] = k;
    endtask

    task automatic fips_block(input string tag);
        clear_logs();
        set_req(2, 1'b1, FIPS_PT, FIPS_KEY);
        tick();
        req_valid = '0;
        repeat (LATENCY + 4) tick();
        check({tag, "_grants"}, 128'(gnt_log.size()), 128'd1);
        check({tag, "_resps"}, 128'(resp_v_log.size()), 128'd1);
        if (gnt_log.size() == 1 && resp_v_log.size() == 1) begin
            check({tag, "_gnt_id"}, 128'(gnt_log[0]), 128'd2);
            check({tag, "_resp_v"}, 128'(resp_v_log[0]), 128'(4'b0100));
            check({tag, "_latency"}, 128'(resp_cyc[0] - gnt_cyc[0]), 128'(LATENCY + 2));
            check({tag, "_ct"}, resp_d_log[0], FIPS_CT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_data = '0;
        req_key = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_core_data", core_data_o, 128'd0);
        check("rst_core_key", core_key_o, 128'd0);
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_resp_data", resp_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(req_ready), 128'd0);

        // Pin the AES model to published vectors
        check("aes_fips_c1", aes128(FIPS_PT, FIPS_KEY), FIPS_CT);
        check("aes_fips_b", aes128(128'h3243f6a8885a308d313198a2e0370734,
                                   128'h2b7e151628aed2a6abf7158809cf4f3c),
              128'h3925841d02dc09fbdc118597196a0b32);

        // Single FIPS block from requester 2
        fips_block("fips");

        // Round-robin with all requesters valid
        do_reset();
        clear_logs();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, pat(i, c, 1), pat(c, i, 2));
            tick();
        end
        req_valid = '0;
        repeat (LATENCY + 4) tick();
        check("rr_count", 128'(gnt_log.size()), 128'd8);
        check("rr_resp_count", 128'(resp_v_log.size()), 128'd8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++)
            check("rr_order", 128'(gnt_log[k]), 128'(k % NREQ));
        for (int k = 0; k < 8 && k < resp_v_log.size(); k++) begin
            check("rr_resp_order", 128'(resp_v_log[k]), 128'(4'b0001 << (k % NREQ)));
            check("rr_resp_back2back", 128'(resp_cyc[k] - resp_cyc[0]), 128'(k));
        end

        // Outstanding limit on requester 1
        do_reset();
        clear_logs();
        for (int c = 0; c < LATENCY + 8; c++) begin
            set_req(1, 1'b1, pat(1, c, 3), pat(1, c, 4));
            tick();
        end
        req_valid = '0;
        repeat (LATENCY + 12) tick();
        if (gnt_cyc.size() >= 5 && resp_cyc.size() >= 1) begin
            check("lim_first4", 128'(gnt_cyc[3] - gnt_cyc[0]), 128'd3);
            check("lim_stall", 128'(gnt_cyc[4] - gnt_cyc[3]), 128'(LATENCY - 1));
            check("lim_credit", 128'(gnt_cyc[4] - resp_cyc[0]), 128'd0);
        end else begin
            check("lim_activity", 128'(gnt_cyc.size()), 128'd5);
        end
        check("lim_resp_match", 128'(resp_v_log.size()), 128'(gnt_log.size()));

        // Issue and return for requester 3 on the same edge
        do_reset();
        clear_logs();
        set_req(3, 1'b1, pat(3, 0, 5), pat(3, 0, 6));
        tick();
        req_valid = '0;
        repeat (LATENCY) tick();
        for (int c = 1; c <= 6; c++) begin
            set_req(3, 1'b1, pat(3, c, 5), pat(3, c, 6));
            tick();
        end
        req_valid = '0;
        repeat (LATENCY + 6) tick();
        check("coll_grants", 128'(gnt_log.size()), 128'd5);
        check("coll_resps", 128'(resp_v_log.size()), 128'd5);
        if (gnt_cyc.size() >= 2 && resp_cyc.size() >= 1) begin
            check("coll_same_edge", 128'(gnt_cyc[1] - gnt_cyc[0]), 128'(LATENCY + 1));
            check("coll_resp_cycle", 128'(resp_cyc[0] - gnt_cyc[1]), 128'd1);
        end

        // Reset while six blocks are in flight
        do_reset();
        clear_logs();
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, pat(0, c, 7), pat(0, c, 8));
            set_req(1, 1'b1, pat(1, c, 7), pat(1, c, 8));
            tick();
        end
        req_valid = '0;
        check("mid_issued", 128'(gnt_log.size()), 128'd6);
        check("mid_busy_before", 128'(busy), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy_after", 128'(busy), 128'd0);
        repeat (2 * LATENCY) tick();
        check("mid_no_resp", 128'(resp_v_log.size()), 128'd0);
        fips_block("post_rst");

        // All valid: round-robin or strict priority for requester 0
        do_reset();
        clear_logs();
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, pat(i, c, 9), pat(c, i, 10));
            tick();
        end
        req_valid = '0;
        repeat (LATENCY + 8) tick();
        check("all_grants", 128'(gnt_log.size()), 128'd16);
        if (gnt_log.size() >= 16) begin
`ifdef AES_SCHED_PRIO_EN
            for (int k = 0; k < 4; k++) check("prio_r0_first", 128'(gnt_log[k]), 128'd0);
            for (int k = 4; k < 7; k++) check("prio_rotate", 128'(gnt_log[k]), 128'(k - 3));
            check("prio_r0_resume", 128'(gnt_log[LATENCY + 2]), 128'd0);
`else
            for (int k = 0; k < 8; k++) check("all_rr", 128'(gnt_log[k]), 128'(k % NREQ));
`endif
        end
        check("all_resps", 128'(resp_v_log.size()), 128'(gnt_log.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
